// File: rtl/pipe_control_if.sv
// ID-stage instruction/hazard inputs and staged control outputs of pipe_control.
// The master drives the ID fields and br_taken; the slave (pipe_control) drives the rest.
interface pipe_control_if #(
  parameter int unsigned OP_W  = 4,
  parameter int unsigned FN_W  = 4,
  parameter int unsigned RA_W  = 4,
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [OP_W-1:0]  id_opCode;
  logic [FN_W-1:0]  id_funCode;
  logic [RA_W-1:0]  id_src1;
  logic [RA_W-1:0]  id_src2;
  logic [RA_W-1:0]  id_dst;
  logic             br_taken;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             id_jump;
  logic [2:0]       ex_aluOp;
  logic             ex_aluSrc;
  logic [1:0]       ex_branch;
  logic [1:0]       mem_read;
  logic [1:0]       mem_write;
  logic             wb_regWrite;
  logic [1:0]       wb_memToReg;
  logic [RA_W-1:0]  wb_dst;
  logic             halted;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_opCode, id_funCode, id_src1, id_src2, id_dst, br_taken,
    input  pc_write, ifid_write, ifid_flush, id_jump, ex_aluOp, ex_aluSrc, ex_branch,
           mem_read, mem_write, wb_regWrite, wb_memToReg, wb_dst, halted, stall_count
  );

  modport slave (
    input  id_valid, id_opCode, id_funCode, id_src1, id_src2, id_dst, br_taken,
    output pc_write, ifid_write, ifid_flush, id_jump, ex_aluOp, ex_aluSrc, ex_branch,
           mem_read, mem_write, wb_regWrite, wb_memToReg, wb_dst, halted, stall_count
  );
endinterface

// File: rtl/pipe_control.sv
// Pipelined control unit: ID decode, EX/MEM/WB control slices, load-use and
// taken-branch hazard handling, and a halt-drain state machine.
module pipe_control #(
  parameter int unsigned    OP_W    = 4,
  parameter int unsigned    FN_W    = 4,
  parameter int unsigned    RA_W    = 4,
  parameter logic [OP_W-1:0] HALT_OP = '1,
  parameter int unsigned    CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  pipe_control_if.slave bus
);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BGT   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BLT   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BE    = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JMP   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_LBU   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_SB    = OP_W'(11);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(12);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(13);

  typedef struct packed {
    logic            rw;
    logic [1:0]      m2r;
    logic [RA_W-1:0] dst;
  } wb_t;

  typedef struct packed {
    logic [1:0] rd;
    logic [1:0] wr;
    wb_t        wb;
  } mem_t;

  typedef struct packed {
    logic [2:0] alu;
    logic       src;
    logic [1:0] br;
    mem_t       mem;
  } ex_t;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_e;

  ex_t              dec;
  ex_t              ex_d, ex_q;
  mem_t             mem_d, mem_q;
  wb_t              wb_d, wb_q;
  state_e           state_d, state_q;
  logic [1:0]       drain_d, drain_q;
  logic             halted_d, halted_q;
  logic [CNT_W-1:0] stall_count_d, stall_count_q;

  logic running, is_jmp, is_halt, load_use, jump_c, flush_c, halt_go, issue;
  logic unused_fn;

  assign unused_fn = ^bus.id_funCode;

  // Instruction decode; destination is carried only when the register file is written.
  always_comb begin
    dec = '0;
    if (bus.id_valid) begin
      case (bus.id_opCode)
        OP_RTYPE: begin dec.alu = bus.id_funCode[2:0]; dec.mem.wb.rw = 1'b1; end
        OP_ANDI:  begin dec.alu = 3'b010; dec.src = 1'b1; dec.mem.wb.rw = 1'b1; end
        OP_ORI:   begin dec.alu = 3'b011; dec.src = 1'b1; dec.mem.wb.rw = 1'b1; end
        OP_LBU:   begin
          dec.src = 1'b1; dec.mem.rd = 2'b01; dec.mem.wb.m2r = 2'b01; dec.mem.wb.rw = 1'b1;
        end
        OP_LW:    begin
          dec.src = 1'b1; dec.mem.rd = 2'b10; dec.mem.wb.m2r = 2'b10; dec.mem.wb.rw = 1'b1;
        end
        OP_SB:    begin dec.src = 1'b1; dec.mem.wr = 2'b01; end
        OP_SW:    begin dec.src = 1'b1; dec.mem.wr = 2'b10; end
        OP_BGT:   begin dec.alu = 3'b001; dec.br = 2'b01; end
        OP_BLT:   begin dec.alu = 3'b001; dec.br = 2'b10; end
        OP_BE:    begin dec.alu = 3'b001; dec.br = 2'b11; end
        default:  dec = '0;
      endcase
    end
    if (dec.mem.wb.rw) dec.mem.wb.dst = bus.id_dst;
  end

  // Hazards: a taken branch overrides everything; a stalled JMP waits in ID.
  always_comb begin
    running  = (state_q == S_RUN);
    is_jmp   = bus.id_valid && (bus.id_opCode == OP_JMP);
    is_halt  = bus.id_valid && (bus.id_opCode == HALT_OP);
    load_use = running && bus.id_valid && !bus.br_taken &&
               (ex_q.mem.rd != 2'b00) && ex_q.mem.wb.rw &&
               ((ex_q.mem.wb.dst == bus.id_src1) || (ex_q.mem.wb.dst == bus.id_src2));
    jump_c   = running && is_jmp && !bus.br_taken && !load_use;
    flush_c  = bus.br_taken || jump_c;
    halt_go  = running && is_halt && !bus.br_taken;
    issue    = running && bus.id_valid && !bus.br_taken && !load_use;
  end

  assign bus.pc_write   = !rst && running && !load_use && !halt_go;
  assign bus.ifid_write = !rst && running && !load_use && !halt_go;
  assign bus.ifid_flush = !rst && flush_c;
  assign bus.id_jump    = !rst && jump_c;

  // Stage shift, halt-drain FSM and saturating stall counter.
  always_comb begin
    ex_d    = issue ? dec : '0;
    mem_d   = ex_q.mem;
    wb_d    = mem_q.wb;
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_RUN: begin
        if (halt_go) begin
          state_d = S_DRAIN;
          drain_d = 2'd0;
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'd2) state_d = S_HALTED;
        else                 drain_d = drain_q + 2'd1;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase
    halted_d      = (state_d == S_HALTED);
    stall_count_d = stall_count_q;
    if ((load_use || flush_c) && (stall_count_q != '1))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      state_q       <= S_RUN;
      drain_q       <= 2'd0;
      halted_q      <= 1'b0;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      state_q       <= state_d;
      drain_q       <= drain_d;
      halted_q      <= halted_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.ex_aluOp    = ex_q.alu;
  assign bus.ex_aluSrc   = ex_q.src;
  assign bus.ex_branch   = ex_q.br;
  assign bus.mem_read    = mem_q.rd;
  assign bus.mem_write   = mem_q.wr;
  assign bus.wb_regWrite = wb_q.rw;
  assign bus.wb_memToReg = wb_q.m2r;
  assign bus.wb_dst      = wb_q.dst;
  assign bus.halted      = halted_q;
  assign bus.stall_count = stall_count_q;

endmodule

// File: doc/pipe_control.md
# pipe_control

Parametrised pipelined control unit for the 4-stage-after-fetch datapath. It decodes the ID-stage instruction and carries the control word through registered EX, MEM and WB stage slices. It also detects load-use and taken-branch hazards, producing the stall, flush and bubble signals, and runs a halt-drain state machine. It replaces the purely combinational decoder; datapath muxes consume its staged outputs directly.

## Interface
- OP_W, 4, opcode width
- FN_W, 4, function-code width
- RA_W, 4, register-address width
- HALT_OP, all-ones of OP_W, halt opcode
- CNT_W, 16, stall-counter width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_opCode  in  OP_W  ID opcode
- id_funCode  in  FN_W  ID function code (opcode 0 only)
- id_src1, id_src2  in  RA_W  ID source registers
- id_dst  in  RA_W  ID destination register
- br_taken  in  1  EX-stage branch resolved taken
- pc_write  out  1  PC may advance
- ifid_write  out  1  IF/ID register may load
- ifid_flush  out  1  zero IF/ID register next edge
- id_jump  out  1  ID holds JMP (comb.)
- ex_aluOp  out  3  ADD=000 SUB=001 AND=010 OR=011 PASS=111
- ex_aluSrc  out  1  1 = immediate operand
- ex_branch  out  2  00 none, 01 BGT, 10 BLT, 11 BE
- mem_read, mem_write  out  2  00 none, 01 byte, 10 word
- wb_regWrite  out  1  write register file
- wb_memToReg  out  2  00 ALU, 01 zero-extended byte, 10 word
- wb_dst  out  RA_W  write-back register
- halted  out  1  pipeline drained after HALT
- stall_count  out  CNT_W  saturating count of stall/flush cycles

## Operation
- Decode (valid only): 0 R-type, aluOp=funCode[2:0], regWrite; 1 ANDI and 2 ORI with aluSrc=1, regWrite; 10 LBU, 12 LW: ADD, aluSrc, read 01/10, memToReg 01/10, regWrite; 11 SB, 13 SW: ADD, aluSrc, write 01/10; 4 BGT, 5 BLT, 6 BE: SUB, branch 01/10/11; 7 JMP: id_jump=1, ifid_flush=1, enters EX as NOP; HALT_OP: handled by the FSM; all other opcodes are NOP (all-zero control word).
- Stage slices EX→MEM→WB shift every cycle. The pipeline never freezes past ID, and a bubble is an all-zero word.
- Load-use: EX mem_read≠0, EX regWrite, and EX dst equals id_src1 or id_src2 while id_valid. Response: pc_write=0, ifid_write=0, bubble into EX. Exactly one stall cycle per hazard.
- Taken branch: br_taken=1 gives ifid_flush=1, and the ID instruction is replaced by a bubble. Branch takes priority over load-use and JMP, and cancels a HALT sitting in ID.
- Halt FSM, states RUN, DRAIN, HALTED:
  - RUN→DRAIN when HALT is in ID, valid, and not flushed. HALT enters EX as a bubble.
  - DRAIN lasts 3 cycles (2-bit counter), then HALTED.
  - In DRAIN and HALTED, pc_write=0, ifid_write=0 and the ID decode is forced to bubble.
  - HALTED sets halted=1 and holds until rst.
- stall_count increments on each cycle with load-use stall or ifid_flush asserted, and saturates at all-ones.

## Timing
- Reset, one cycle, synchronous: all stage slices zero, wb_dst=0, FSM=RUN, drain counter=0, halted=0, stall_count=0. While rst=1, pc_write=ifid_write=0 and ifid_flush=id_jump=0.
- Decode→ex_* latency 1 cycle, →mem_* 2, →wb_* 3.
- pc_write, ifid_write, ifid_flush and id_jump are combinational from current inputs and state.
- halted rises on the 4th edge after the edge that latched HALT into ID-accepted state (3 DRAIN cycles).
- Reset asserted in DRAIN returns to RUN with empty stages. Simultaneous load-use and br_taken counts 1 stall cycle.

## Test plan
- Reset, then R-type op 0 fun 4 at ID: ex_aluOp=100 after 1 clock, wb_regWrite=1 and wb_memToReg=00 after 3 clocks.
- LW dst=3, then ADD src1=3: one cycle with pc_write=0 and ifid_write=0, EX bubble, stall_count=1, ADD reaches EX next cycle.
- BE in EX with br_taken=1 and LW-dependent instruction in ID: ifid_flush=1, EX bubble, no stall, stall_count +1 only.
- Opcodes 10/11/12/13 in sequence: mem_read 01,00,10,00 and mem_write 00,01,00,10 on consecutive cycles starting 2 clocks later.
- HALT after ORI: ORI completes (wb_regWrite=1), pc_write=0 from HALT decode on, halted=1 after 3 drain cycles, then stays 1; rst clears it.
- HALT in ID with br_taken=1: FSM remains RUN, halted stays 0; JMP then gives id_jump=1, ifid_flush=1.
